lc3b_rob: RTL

LC3B_ROB -- requirements
Module: lc3b_rob

---
 rtl/lc3b_rob_pkg.sv | 25 ++
 rtl/lc3b_rob_ptr.sv | 22 ++
 rtl/lc3b_rob.sv | 113 +++++++++++
 3 files changed

// File: rtl/lc3b_rob_pkg.sv
// Shared LC-3b out-of-order types: register/ROB indices, CDB beat and ROB entry.
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_rob_addr;
  typedef logic [15:0] lc3b_word;

  // Common data bus beat: a result tagged with the ROB slot that produced it.
  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } CDB;

  typedef struct packed {
    logic     busy;
    logic     ready;
    logic     wr_reg;
    lc3b_reg  dest;
    lc3b_word data;
  } rob_entry_t;

  localparam int ROB_DEPTH = 2 ** $bits(lc3b_rob_addr);

endpackage

// File: rtl/lc3b_rob_ptr.sv
// Wrapping circular-buffer pointer with increment and synchronous clear.
module rob_ptr
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output lc3b_rob_addr ptr
);

  // Clear wins over increment; the natural overflow gives the 7 -> 0 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + lc3b_rob_addr'(1);
  end

endmodule

// File: rtl/lc3b_rob.sv
// Reorder buffer: in-order allocate, out-of-order CDB completion, in-order commit.
module lc3b_rob
  import lc3b_types::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alloc_valid,
  input  lc3b_reg      alloc_dest,
  input  logic         alloc_wr_reg,
  output lc3b_rob_addr alloc_tag,
  output logic         full,
  input  CDB           cdb_in,
  input  lc3b_rob_addr rd_tag_a,
  input  lc3b_rob_addr rd_tag_b,
  output logic         rd_ready_a,
  output logic         rd_ready_b,
  output lc3b_word     rd_data_a,
  output lc3b_word     rd_data_b,
  output logic         commit_valid,
  output lc3b_rob_addr commit_tag,
  output lc3b_reg      commit_dest,
  output logic         commit_wr_reg,
  output lc3b_word     commit_data,
  input  logic         flush,
  output logic [3:0]   count
);

  rob_entry_t   entries [DEPTH];
  lc3b_rob_addr head;
  lc3b_rob_addr tail;
  logic         alloc_ok;
  logic         cdb_wr;

  // full comes from the registered count, so a same-cycle commit cannot open a slot.
  assign full         = (count == 4'(DEPTH));
  assign alloc_ok     = alloc_valid && !full && !flush;
  assign cdb_wr       = cdb_in.valid && entries[cdb_in.tag].busy && !flush;
  assign commit_valid = entries[head].busy && entries[head].ready && !flush;

  assign alloc_tag     = tail;
  assign commit_tag    = head;
  assign commit_dest   = entries[head].dest;
  assign commit_wr_reg = entries[head].wr_reg;
  assign commit_data   = entries[head].data;

  rob_ptr u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (commit_valid),
    .ptr   (head)
  );

  rob_ptr u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (alloc_ok),
    .ptr   (tail)
  );

  // Occupancy tracking; head==tail is resolved by this count (0 empty, DEPTH full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (flush)
      count <= '0;
    else if (alloc_ok && !commit_valid)
      count <= count + 4'd1;
    else if (!alloc_ok && commit_valid)
      count <= count - 4'd1;
  end

  // Entry updates; the commit clear is written last so it overrides a CDB to the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
    end else begin
      if (cdb_wr) begin
        entries[cdb_in.tag].ready <= 1'b1;
        entries[cdb_in.tag].data  <= cdb_in.data;
      end
      if (alloc_ok)
        entries[tail] <= '{busy: 1'b1, ready: 1'b0, wr_reg: alloc_wr_reg,
                           dest: alloc_dest, data: '0};
      if (commit_valid)
        entries[head] <= '0;
    end
  end

  // Operand lookup with same-cycle CDB bypass into a busy, not-yet-written entry.
  always_comb begin
    rd_ready_a = entries[rd_tag_a].ready;
    rd_data_a  = entries[rd_tag_a].data;
    if (cdb_in.valid && cdb_in.tag == rd_tag_a && entries[rd_tag_a].busy) begin
      rd_ready_a = 1'b1;
      rd_data_a  = cdb_in.data;
    end
    rd_ready_b = entries[rd_tag_b].ready;
    rd_data_b  = entries[rd_tag_b].data;
    if (cdb_in.valid && cdb_in.tag == rd_tag_b && entries[rd_tag_b].busy) begin
      rd_ready_b = 1'b1;
      rd_data_b  = cdb_in.data;
    end
  end

endmodule
